conv_row_accum: RTL and testbench
=================================

# conv_row_accum

Downstream stage of the 11-wide row multiply-add unit. Accumulates one floating-point row dot product per row of an 11×11 convolution window into a single output pixel, then adds the per-filter bias and optionally applies ReLU. Presents the pixel on a valid/ready handshake to the output/pooling stage. It also back-pressures its upstream controller through `in_ready`, so the row unit is only enabled while a row can be accepted.

## Interface
- `DATA_WIDTH`, 16: width of one IEEE-754 binary float; default is half precision.
- `KERNEL_ROWS`, 11: number of row partial sums per output pixel; legal range 1..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `clr` input 1: synchronous abort; returns the block to IDLE and discards the partial sum.
- `in_valid` input 1: `in_data` holds a valid row partial sum.
- `in_data` input DATA_WIDTH: row partial sum from the row multiply-add unit.
- `in_ready` output 1: block accepts a row this cycle. A row is accepted when `in_valid && in_ready`.
- `bias` input DATA_WIDTH: filter bias; sampled on acceptance of the first row of a pixel.
- `relu_en` input 1: sampled on acceptance of the first row; enables ReLU on the result.
- `out_valid` output 1: `out_data` holds a finished pixel.
- `out_data` output DATA_WIDTH: finished pixel.
- `out_ready` input 1: consumer takes the pixel when `out_valid && out_ready`.

## Operation
- Datapath:
  - One `floating_point_add` instance, treated as combinational.
  - Operand A is `acc`. Operand B is `in_data` in ACCUM and `bias_q` in BIAS.
  - Sum is registered into `acc`.
  - Row counter `cnt` is 8 bits.
  - Registers `bias_q` and `relu_q` hold the values latched with the first row.
- States:
  - **IDLE**
    - `in_ready`=1.
    - On accept: `acc`←`in_data` (no add), `cnt`←1, latch `bias_q` and `relu_q`.
    - Next state is BIAS if KERNEL_ROWS==1, otherwise ACCUM.
  - **ACCUM**
    - `in_ready`=1.
    - On accept: `acc`←`acc`+`in_data`, `cnt`←`cnt`+1.
    - If `cnt`==KERNEL_ROWS-1 at accept, go to BIAS.
    - Cycles without `in_valid` hold all state; gaps are unlimited.
  - **BIAS**
    - `in_ready`=0.
    - One cycle: `out_data`←ReLU(`acc`+`bias_q`), `out_valid`←1, go to OUT.
  - **OUT**
    - `in_ready`=0; `out_data` and `out_valid` are held stable.
    - On `out_ready`: `out_valid`←0, `acc`←0, `cnt`←0, go to IDLE.
- ReLU: if `relu_q`=1 and the sum's sign bit (MSB) is 1, the result is all-zero. This covers negatives and −0. Otherwise the sum passes unchanged.
- `in_valid` while `in_ready`=0 is ignored; upstream must hold the data.
- `clr` takes priority over every transition:
  - Next cycle: IDLE, `acc`=0, `cnt`=0, `out_valid`=0.
  - A pending output is dropped.
  - A row presented in the same cycle as `clr` is not accepted.
- Reset values: `in_ready`=0 while `rst` is asserted (IDLE drives 1 after release). `out_valid`=0, `out_data`=0, `acc`=0, `cnt`=0, `bias_q`=0, `relu_q`=0, state IDLE.
- Asserting `rst` mid-accumulation or mid-OUT discards everything immediately (asynchronous).

## Timing
- Accept-to-accept for rows: 1 cycle minimum, full throughput within a pixel.
- Last row accepted at edge N: state is BIAS after N; `out_valid`=1 after edge N+1.
- Pixel period with no stalls: KERNEL_ROWS + 2 cycles, i.e. 13 at the default. This is KERNEL_ROWS accept cycles, plus BIAS, plus one OUT cycle with `out_ready`=1.
- `out_ready` held high before `out_valid` rises: handshake completes in the first OUT cycle; IDLE is entered the next cycle.
- The first row of the next pixel is accepted no earlier than the cycle after the handshake.
- `out_data` changes only on the BIAS→OUT edge, or to 0 on reset.

## Test plan
- 11 rows of 16'h3C00 (1.0), bias 16'h3800 (0.5), `relu_en`=0, `out_ready`=1:
  - `out_data`=16'h49C0 (11.5).
  - `out_valid` is high exactly one cycle, two edges after the 11th accept.
- 11 rows of 16'hBC00 (−1.0), bias 16'h3800:
  - `relu_en`=0 → 16'hC940 (−10.5).
  - `relu_en`=1 → 16'h0000.
- `in_valid` with random gaps and `out_ready` held low 5 cycles after `out_valid`:
  - Result unchanged (16'h49C0).
  - `out_data` is stable and `in_ready`=0 throughout the stall.
  - Rows offered during the stall are not consumed.
- `clr` after 6 rows, then 11 fresh rows of 16'h4000 (2.0), bias 0 → `out_data`=16'h4D80 (22.0); the aborted partial sum is not included.
- `rst` pulsed low during ACCUM → outputs return to reset values immediately; the next 11-row pixel of 1.0 + 0.5 yields 16'h49C0.
- KERNEL_ROWS=1: one row 16'h4000 with bias 16'h3C00 → 16'h4200 (3.0), `out_valid` two edges after the accept.

Source files
------------

// File: rtl/conv_row_accum.sv
// Row-sum accumulator for an 11x11 convolution window: sums KERNEL_ROWS float row partials,
// adds the filter bias, optionally applies ReLU and offers the pixel on a valid/ready port.

module floating_point_add #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);
  localparam int EW   = (DATA_WIDTH == 64) ? 11 : (DATA_WIDTH == 32) ? 8 : 5;
  localparam int MW   = DATA_WIDTH - 1 - EW;
  localparam int SW   = MW + 4;
  localparam int EMAX = (1 << EW) - 1;

  logic [DATA_WIDTH-1:0] big, sml;
  logic [SW:0]           mb, ms, sum;
  logic [MW+1:0]         rm;
  logic                  sticky, rnd, sgn;
  int                    eb, es, diff, ex, lz, sh;

  always_comb begin
    // Order operands by magnitude so the aligned subtraction never goes negative.
    if (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    eb = int'(big[DATA_WIDTH-2:MW]);
    es = int'(sml[DATA_WIDTH-2:MW]);
    mb = {1'b0, eb != 0, big[MW-1:0], 3'b000};
    ms = {1'b0, es != 0, sml[MW-1:0], 3'b000};
    if (eb == 0) eb = 1;
    if (es == 0) es = 1;
    diff   = eb - es;
    sticky = 1'b0;
    for (int i = 0; i <= SW; i++)
      if (i < diff && ms[i]) sticky = 1'b1;
    ms    = (diff > SW) ? '0 : ms >> diff;
    ms[0] = ms[0] | sticky;
    sum   = (big[DATA_WIDTH-1] == sml[DATA_WIDTH-1]) ? mb + ms : mb - ms;
    sgn   = big[DATA_WIDTH-1];
    if (sum == '0 && big[DATA_WIDTH-1] != sml[DATA_WIDTH-1]) sgn = 1'b0;
    ex = eb;
    lz = SW;
    for (int i = 0; i < SW; i++)
      if (sum[i]) lz = SW - 1 - i;
    sh = 0;
    if (sum[SW]) begin
      sum = (sum >> 1) | {{SW{1'b0}}, sum[0]};
      ex  = ex + 1;
    end else begin
      // Left-normalise, but stop at the minimum exponent to produce subnormals.
      sh  = (lz > ex - 1) ? ex - 1 : lz;
      sum = sum << sh;
      ex  = ex - sh;
    end
    rnd = sum[2] & (sum[1] | sum[0] | sum[3]);
    rm  = {1'b0, sum[SW-1:3]} + {{(MW+1){1'b0}}, rnd};
    if (rm[MW+1]) begin
      rm = rm >> 1;
      ex = ex + 1;
    end
    if (ex >= EMAX) y = {sgn, {EW{1'b1}}, {MW{1'b0}}};
    else if (rm[MW]) y = {sgn, EW'(ex), rm[MW-1:0]};
    else y = {sgn, {EW{1'b0}}, rm[MW-1:0]};
    if (big[DATA_WIDTH-2:MW] == '1) y = big;
  end
endmodule

module conv_row_accum #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_ROWS = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] bias,
  input  logic                  relu_en,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);
  typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;

  localparam logic [7:0] LAST = 8'(KERNEL_ROWS - 1);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] acc, bias_q, add_b, add_y, pix;
  logic [7:0]            cnt;
  logic                  relu_q, accept;

  // clr gates in_ready so a row offered alongside an abort is not consumed.
  assign in_ready = rst && !clr && (state == IDLE || state == ACCUM);
  assign accept   = in_valid && in_ready;
  assign add_b    = (state == BIAS) ? bias_q : in_data;
  assign pix      = (relu_q && add_y[DATA_WIDTH-1]) ? '0 : add_y;

  floating_point_add #(.DATA_WIDTH(DATA_WIDTH)) u_add (
    .a(acc),
    .b(add_b),
    .y(add_y)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (KERNEL_ROWS == 1) ? BIAS : ACCUM;
      ACCUM:   if (accept && cnt == LAST) state_nxt = BIAS;
      BIAS:    state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      cnt       <= '0;
      bias_q    <= '0;
      relu_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clr) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          acc    <= in_data;
          cnt    <= 8'd1;
          bias_q <= bias;
          relu_q <= relu_en;
        end
        ACCUM: if (accept) begin
          acc <= add_y;
          cnt <= cnt + 8'd1;
        end
        BIAS: begin
          out_data  <= pix;
          out_valid <= 1'b1;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          acc       <= '0;
          cnt       <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_row_accum.sv
// Scoreboarded bench: stimulus pushes expected pixels, monitors pop and compare on each handshake.
module tb_conv_row_accum;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0, relu_en = 1'b0, out_ready = 1'b1;
  logic [15:0] in_data = '0, bias = '0;
  logic        in_ready, out_valid;
  logic [15:0] out_data;

  logic        in_valid1 = 1'b0, out_ready1 = 1'b1;
  logic [15:0] in_data1 = '0, bias1 = '0;
  logic        in_ready1, out_valid1;
  logic [15:0] out_data1;

  int n_chk = 0, n_fail = 0, cyc = 0, last_acc = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  conv_row_accum #(.DATA_WIDTH(16), .KERNEL_ROWS(11)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .bias(bias), .relu_en(relu_en), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready)
  );

  conv_row_accum #(.DATA_WIDTH(16), .KERNEL_ROWS(1)) dut1 (
    .clk(clk), .rst(rst), .clr(1'b0), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .bias(bias1), .relu_en(1'b0), .out_valid(out_valid1),
    .out_data(out_data1), .out_ready(out_ready1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (q0.size() == 0) check("unexpected_pixel", out_data, 16'hxxxx);
      else check("pixel", out_data, q0.pop_front());
    end
    if (out_valid1 && out_ready1) begin
      if (q1.size() == 0) check("unexpected_pixel_k1", out_data1, 16'hxxxx);
      else check("pixel_k1", out_data1, q1.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [15:0] d, input logic [15:0] b, input logic r);
    bit ok;
    int t;
    ok = 1'b0;
    t  = 0;
    in_data = d; bias = b; relu_en = r; in_valid = 1'b1;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = in_ready;
      step();
      t++;
    end
    if (!ok) check("row_accept_timeout", 16'd0, 16'd1);
    last_acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic send_pixel(input logic [15:0] d, input logic [15:0] b, input logic r,
                            input int rows, input bit gaps);
    for (int i = 0; i < rows; i++) begin
      send_row(d, b, r);
      if (gaps) repeat (i % 3) step();
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) check(name, 16'd0, 16'd1);
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!out_valid && t < 50) begin
      step();
      t++;
    end
    if (!out_valid) check("out_valid_timeout", 16'd0, 16'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset_in_ready", {15'd0, in_ready}, 16'd0);
    check("reset_out_valid", {15'd0, out_valid}, 16'd0);
    check("reset_out_data", out_data, 16'h0000);
    step();
    rst = 1'b1;
    #1;
    check("idle_in_ready", {15'd0, in_ready}, 16'd1);

    // 11 x 1.0 + 0.5 with timing of the output pulse
    q0.push_back(16'h49C0);
    send_pixel(16'h3C00, 16'h3800, 1'b0, 11, 1'b0);
    @(negedge clk);
    check("bias_cycle_out_valid", {15'd0, out_valid}, 16'd0);
    check("bias_cycle_in_ready", {15'd0, in_ready}, 16'd0);
    check("bias_cycle_edge", 16'(cyc - last_acc), 16'd0);
    @(negedge clk);
    check("out_cycle_out_valid", {15'd0, out_valid}, 16'd1);
    @(negedge clk);
    check("after_hs_out_valid", {15'd0, out_valid}, 16'd0);
    check("after_hs_in_ready", {15'd0, in_ready}, 16'd1);
    step();
    wait_drain("drain_pos");

    q0.push_back(16'hC940);
    send_pixel(16'hBC00, 16'h3800, 1'b0, 11, 1'b0);
    wait_drain("drain_neg");
    q0.push_back(16'h0000);
    send_pixel(16'hBC00, 16'h3800, 1'b1, 11, 1'b0);
    wait_drain("drain_relu");

    // gaps on input, output stalled five cycles while a row is offered
    out_ready = 1'b0;
    q0.push_back(16'h49C0);
    send_pixel(16'h3C00, 16'h3800, 1'b0, 11, 1'b1);
    wait_valid();
    in_valid = 1'b1;
    in_data  = 16'h7777;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_data", out_data, 16'h49C0);
      check("stall_out_valid", {15'd0, out_valid}, 16'd1);
      check("stall_in_ready", {15'd0, in_ready}, 16'd0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain("drain_stall");
    step();

    // clr while OUT drops the pending pixel
    out_ready = 1'b0;
    send_pixel(16'h3C00, 16'h3800, 1'b0, 11, 1'b0);
    wait_valid();
    clr = 1'b1;
    step();
    clr = 1'b0;
    #1;
    check("clr_drop_out_valid", {15'd0, out_valid}, 16'd0);
    check("clr_drop_in_ready", {15'd0, in_ready}, 16'd1);
    out_ready = 1'b1;

    // clr after 6 rows; the row offered with clr is not taken
    send_pixel(16'h3C00, 16'h3800, 1'b0, 6, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'h3C00;
    clr      = 1'b1;
    @(negedge clk);
    check("clr_in_ready", {15'd0, in_ready}, 16'd0);
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    q0.push_back(16'h4D80);
    send_pixel(16'h4000, 16'h0000, 1'b0, 11, 1'b0);
    wait_drain("drain_clr");
    check("hold_out_data", out_data, 16'h4D80);

    // asynchronous reset mid-accumulation
    send_pixel(16'h3C00, 16'h3800, 1'b0, 5, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_in_ready", {15'd0, in_ready}, 16'd0);
    step();
    rst = 1'b1;
    q0.push_back(16'h49C0);
    send_pixel(16'h3C00, 16'h3800, 1'b0, 11, 1'b0);
    wait_drain("drain_rst");

    // single-row kernel
    q1.push_back(16'h4200);
    in_data1 = 16'h4000; bias1 = 16'h3C00; in_valid1 = 1'b1;
    @(negedge clk);
    check("k1_in_ready", {15'd0, in_ready1}, 16'd1);
    step();
    in_valid1 = 1'b0;
    @(negedge clk);
    check("k1_bias_out_valid", {15'd0, out_valid1}, 16'd0);
    @(negedge clk);
    check("k1_out_valid", {15'd0, out_valid1}, 16'd1);
    step();
    wait_drain("drain_k1");

    check("scoreboard_empty", 16'(q0.size() + q1.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
